// File: rtl/bp_defs.sv
// bp_defs: shared branch-predictor definitions.
// Holds the default PHT index width, the 2-bit saturating-counter encodings
// (shared with the PHT itself) and the field widths of an update-queue entry.
package bp_defs;

  localparam int LOGINDEXSIZE_DEF = 12;

  // 2-bit saturating counter states; the MSB is the predicted direction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_ctr_e;

  // Entry layout is {index, pred}; pred occupies the LSB.
  localparam int PRED_W = 1;

  function automatic int entry_w(input int logindexsize);
    return logindexsize + PRED_W;
  endfunction

endpackage

// File: rtl/pht_uq_fifo.sv
// pht_uq_fifo: circular-buffer FIFO with flush-to-read-pointer.
// Pointers carry one extra MSB to tell full from empty.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   push_i/push_data_i  write request and payload (dropped when full or flushing)
//   pop_i               read request (ignored when empty)
//   flush_i             discard all entries younger than the read pointer
//   head_o              entry at the read pointer
//   pop_ok_o            pop accepted this cycle
//   full_o, empty_o     occupancy flags
//   count_o             wr_ptr - rd_ptr
module pht_uq_fifo #(
  parameter int WIDTH    = 13,
  parameter int DEPTH    = 8,
  parameter int LOGDEPTH = 3
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [WIDTH-1:0]    push_data_i,
  input  logic                pop_i,
  input  logic                flush_i,
  output logic [WIDTH-1:0]    head_o,
  output logic                pop_ok_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [LOGDEPTH:0]   count_o
);

  localparam logic [LOGDEPTH:0] PTR_ONE = {{LOGDEPTH{1'b0}}, 1'b1};

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [LOGDEPTH:0] wr_ptr_q, wr_ptr_d;
  logic [LOGDEPTH:0] rd_ptr_q, rd_ptr_d;
  logic              push_ok;

  assign full_o   = (wr_ptr_q[LOGDEPTH] != rd_ptr_q[LOGDEPTH]) &&
                    (wr_ptr_q[LOGDEPTH-1:0] == rd_ptr_q[LOGDEPTH-1:0]);
  assign empty_o  = (wr_ptr_q == rd_ptr_q);
  assign count_o  = wr_ptr_q - rd_ptr_q;
  assign push_ok  = push_i & ~full_o & ~flush_i;
  assign pop_ok_o = pop_i & ~empty_o;
  assign head_o   = mem_q[rd_ptr_q[LOGDEPTH-1:0]];

  // A flush snaps the write pointer onto the post-pop read pointer, so the
  // entry popped in the same cycle is still consumed.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (pop_ok_o) rd_ptr_d = rd_ptr_q + PTR_ONE;
    if (flush_i)      wr_ptr_d = rd_ptr_d;
    else if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload is never reset; only the pointers define validity.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[LOGDEPTH-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pht_update_queue.sv
// pht_update_queue: commit-side writer for the 2-bit pattern history table.
// Records {index, predicted direction} at fetch in program order, retires
// in order at commit, drives the PHT write port one cycle later and flags
// mispredictions. A flush discards all uncommitted entries.
// Ports:
//   clock, reset_n                       clock, asynchronous active-low reset
//   enq_valid_i/enq_index_i/enq_pred_i   fetch-side record request
//   enq_ready_o                          queue not full
//   cm_valid_i/cm_taken_i                oldest branch commits, resolved direction
//   flush_i                              squash uncommitted entries
//   pht_wt_index_o/pht_cm_brdir_we_o/pht_cm_brdir_o  PHT write port (registered)
//   mispredict_o                         one-cycle pulse on direction mismatch
//   count_o                              number of valid entries
// Optional: define PHT_UPDATE_QUEUE_STATS_EN to add stat_commits_o and
// stat_mispred_o (32-bit wrapping counters).
module pht_update_queue
  import bp_defs::*;
#(
  parameter int LOGINDEXSIZE = LOGINDEXSIZE_DEF,
  parameter int DEPTH        = 8,
  parameter int LOGDEPTH     = 3
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    enq_valid_i,
  output logic                    enq_ready_o,
  input  logic [LOGINDEXSIZE-1:0] enq_index_i,
  input  logic                    enq_pred_i,
  input  logic                    cm_valid_i,
  input  logic                    cm_taken_i,
  input  logic                    flush_i,
  output logic [LOGINDEXSIZE-1:0] pht_wt_index_o,
  output logic                    pht_cm_brdir_we_o,
  output logic                    pht_cm_brdir_o,
  output logic                    mispredict_o,
  output logic [LOGDEPTH:0]       count_o
`ifdef PHT_UPDATE_QUEUE_STATS_EN
  ,
  output logic [31:0]             stat_commits_o,
  output logic [31:0]             stat_mispred_o
`endif
);

  localparam int EW = entry_w(LOGINDEXSIZE);

  logic [EW-1:0]           head;
  logic                    cm_ok;
  logic                    full;
  logic                    empty;
  logic [LOGINDEXSIZE-1:0] idx_q, idx_d;
  logic                    dir_q, dir_d;
  logic                    we_q, we_d;
  logic                    mis_q, mis_d;

  pht_uq_fifo #(
    .WIDTH   (EW),
    .DEPTH   (DEPTH),
    .LOGDEPTH(LOGDEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .push_i     (enq_valid_i),
    .push_data_i({enq_index_i, enq_pred_i}),
    .pop_i      (cm_valid_i),
    .flush_i    (flush_i),
    .head_o     (head),
    .pop_ok_o   (cm_ok),
    .full_o     (full),
    .empty_o    (empty),
    .count_o    (count_o)
  );

  assign enq_ready_o = ~full;

  // Index and direction hold between commits; strobes fall back to 0.
  always_comb begin
    we_d  = 1'b0;
    mis_d = 1'b0;
    idx_d = idx_q;
    dir_d = dir_q;
    if (cm_ok) begin
      we_d  = 1'b1;
      idx_d = head[EW-1:PRED_W];
      dir_d = cm_taken_i;
      mis_d = head[0] ^ cm_taken_i;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_q  <= 1'b0;
      mis_q <= 1'b0;
      idx_q <= '0;
      dir_q <= 1'b0;
    end else begin
      we_q  <= we_d;
      mis_q <= mis_d;
      idx_q <= idx_d;
      dir_q <= dir_d;
    end
  end

  assign pht_cm_brdir_we_o = we_q;
  assign mispredict_o      = mis_q;
  assign pht_wt_index_o    = idx_q;
  assign pht_cm_brdir_o    = dir_q;

`ifdef PHT_UPDATE_QUEUE_STATS_EN
  logic [31:0] commits_q, mispred_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      commits_q <= '0;
      mispred_q <= '0;
    end else begin
      if (cm_ok) commits_q <= commits_q + 32'd1;
      if (mis_d) mispred_q <= mispred_q + 32'd1;
    end
  end

  assign stat_commits_o = commits_q;
  assign stat_mispred_o = mispred_q;
`endif

endmodule

// File: tb/tb_pht_update_queue.sv
module tb_pht_update_queue;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enq_valid_i = 1'b0;
  logic        enq_ready_o;
  logic [11:0] enq_index_i = '0;
  logic        enq_pred_i = 1'b0;
  logic        cm_valid_i = 1'b0;
  logic        cm_taken_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [11:0] pht_wt_index_o;
  logic        pht_cm_brdir_we_o;
  logic        pht_cm_brdir_o;
  logic        mispredict_o;
  logic [3:0]  count_o;
`ifdef PHT_UPDATE_QUEUE_STATS_EN
  logic [31:0] stat_commits_o;
  logic [31:0] stat_mispred_o;
`endif

  pht_update_queue dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enq_valid_i      (enq_valid_i),
    .enq_ready_o      (enq_ready_o),
    .enq_index_i      (enq_index_i),
    .enq_pred_i       (enq_pred_i),
    .cm_valid_i       (cm_valid_i),
    .cm_taken_i       (cm_taken_i),
    .flush_i          (flush_i),
    .pht_wt_index_o   (pht_wt_index_o),
    .pht_cm_brdir_we_o(pht_cm_brdir_we_o),
    .pht_cm_brdir_o   (pht_cm_brdir_o),
    .mispredict_o     (mispredict_o),
    .count_o          (count_o)
`ifdef PHT_UPDATE_QUEUE_STATS_EN
    ,
    .stat_commits_o   (stat_commits_o),
    .stat_mispred_o   (stat_mispred_o)
`endif
  );

  always #5 clock = ~clock;

  // Reference model: a plain queue of {index, pred} plus expected outputs.
  logic [12:0] mq[$];
  logic        e_we, e_dir, e_mis;
  logic [11:0] e_idx;
  int unsigned e_commits, e_mispred;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    e_we = 0; e_dir = 0; e_mis = 0; e_idx = '0;
    e_commits = 0; e_mispred = 0;
  endtask

  task automatic compare_all();
    check("we", {31'd0, pht_cm_brdir_we_o}, {31'd0, e_we});
    check("mispredict", {31'd0, mispredict_o}, {31'd0, e_mis});
    check("index", {20'd0, pht_wt_index_o}, {20'd0, e_idx});
    check("brdir", {31'd0, pht_cm_brdir_o}, {31'd0, e_dir});
    check("count", {28'd0, count_o}, mq.size());
    check("ready", {31'd0, enq_ready_o}, {31'd0, (mq.size() < 8)});
`ifdef PHT_UPDATE_QUEUE_STATS_EN
    check("stat_commits", stat_commits_o, e_commits);
    check("stat_mispred", stat_mispred_o, e_mispred);
`endif
  endtask

  // One clock cycle: drive, apply the rules at the edge, compare after it.
  task automatic cyc(input logic ev, input logic [11:0] ei, input logic ep,
                     input logic cv, input logic ct, input logic fl);
    logic [12:0] e;
    logic        acc_enq, acc_cm;
    enq_valid_i = ev; enq_index_i = ei; enq_pred_i = ep;
    cm_valid_i = cv; cm_taken_i = ct; flush_i = fl;
    @(posedge clock);
    acc_enq = ev && (mq.size() < 8) && !fl;
    acc_cm  = cv && (mq.size() > 0);
    e_we = 0; e_mis = 0;
    if (acc_cm) begin
      e = mq.pop_front();
      e_we = 1; e_idx = e[12:1]; e_dir = ct; e_mis = (e[0] != ct);
      e_commits++;
      if (e_mis) e_mispred++;
    end
    if (fl) mq.delete();
    else if (acc_enq) mq.push_back({ei, ep});
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(0, '0, 0, 0, 0, 0);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && mq.size() > 0; i++) cyc(0, '0, 0, 1, 0, 0);
    check("drained", mq.size(), 0);
  endtask

  initial begin
    model_reset();
    #12;
    // Reset state held while reset_n is low
    check("rst_we", {31'd0, pht_cm_brdir_we_o}, 0);
    check("rst_mis", {31'd0, mispredict_o}, 0);
    check("rst_idx", {20'd0, pht_wt_index_o}, 0);
    check("rst_cnt", {28'd0, count_o}, 0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;
    check("rst_ready", {31'd0, enq_ready_o}, 1);

    // Single mispredicted branch
    cyc(1, 12'h0A5, 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    check("t1_we", {31'd0, pht_cm_brdir_we_o}, 1);
    check("t1_idx", {20'd0, pht_wt_index_o}, 32'h0A5);
    check("t1_dir", {31'd0, pht_cm_brdir_o}, 0);
    check("t1_mis", {31'd0, mispredict_o}, 1);
    idle();
    check("t1_mis_pulse", {31'd0, mispredict_o}, 0);
    check("t1_idx_hold", {20'd0, pht_wt_index_o}, 32'h0A5);

    // Fill to full, refused 9th enqueue, then commit one
    for (int i = 0; i < 8; i++) cyc(1, 12'h100 + 12'(i), i[0], 0, 0, 0);
    check("full_cnt", {28'd0, count_o}, 8);
    check("full_rdy", {31'd0, enq_ready_o}, 0);
    cyc(1, 12'hFFF, 1, 0, 0, 0);
    check("full_9th", {28'd0, count_o}, 8);
    cyc(0, '0, 0, 1, 1, 0);
    check("full_pop_cnt", {28'd0, count_o}, 7);
    check("full_pop_rdy", {31'd0, enq_ready_o}, 1);
    check("full_pop_idx", {20'd0, pht_wt_index_o}, 32'h100);
    // Enqueue+commit while full: only the commit happens
    cyc(1, 12'h200, 0, 0, 0, 0);
    cyc(1, 12'h201, 0, 1, 0, 0);
    check("full_both_cnt", {28'd0, count_o}, 7);
    drain();

    // Flush with same-cycle commit and enqueue
    for (int i = 0; i < 5; i++) cyc(1, 12'h300 + 12'(i), 1, 0, 0, 0);
    cyc(1, 12'h3FF, 0, 1, 1, 1);
    check("fl_we", {31'd0, pht_cm_brdir_we_o}, 1);
    check("fl_idx", {20'd0, pht_wt_index_o}, 32'h300);
    check("fl_cnt", {28'd0, count_o}, 0);

    // Commit against empty queue
    cyc(0, '0, 0, 1, 0, 0);
    check("empty_we", {31'd0, pht_cm_brdir_we_o}, 0);
    check("empty_mis", {31'd0, mispredict_o}, 0);

    // Streaming enqueue/commit across the pointer wrap
    cyc(1, 12'h400, 0, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      cyc(1, 12'h400 + 12'(i), i[0], 1, ~i[0], 0);
      check("stream_cnt", {28'd0, count_o}, 1);
      check("stream_idx", {20'd0, pht_wt_index_o}, 32'h400 + i - 1);
    end
    drain();

    // Randomised traffic
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 9) < 7), 12'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 1), 1'($urandom), ($urandom_range(0, 19) == 0));

    // Asynchronous reset with a commit pending
    for (int i = 0; i < 3; i++) cyc(1, 12'h500 + 12'(i), 1, 0, 0, 0);
    cyc(0, '0, 0, 1, 0, 0);
    enq_valid_i = 0; cm_valid_i = 1; flush_i = 0;
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check("arst_we", {31'd0, pht_cm_brdir_we_o}, 0);
    check("arst_idx", {20'd0, pht_wt_index_o}, 0);
    check("arst_cnt", {28'd0, count_o}, 0);
    compare_all();
    cm_valid_i = 0;
    @(negedge clock);
    reset_n = 1'b1;
    idle();
    for (int i = 0; i < 100; i++)
      cyc(($urandom_range(0, 9) < 6), 12'($urandom), 1'($urandom),
          ($urandom_range(0, 1) == 1), 1'($urandom), ($urandom_range(0, 29) == 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
